// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: symbol geometry, DVI control tokens and aligner FSM states.
package tmds_pkg;

  localparam int unsigned SYMBOL_W = 10;
  localparam int unsigned OFFSET_W = 4;

  // Tokens written bit 9..0; bit 0 is the first bit on the wire.
  localparam logic [SYMBOL_W-1:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [SYMBOL_W-1:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [SYMBOL_W-1:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [SYMBOL_W-1:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  // Returns {hit, C1, C0}; C1/C0 are zero when the symbol is not a control token.
  function automatic logic [2:0] ctrl_decode(input logic [SYMBOL_W-1:0] sym);
    case (sym)
      CTRL_TOK_00: ctrl_decode = 3'b1_00;
      CTRL_TOK_01: ctrl_decode = 3'b1_01;
      CTRL_TOK_10: ctrl_decode = 3'b1_10;
      CTRL_TOK_11: ctrl_decode = 3'b1_11;
      default:     ctrl_decode = 3'b0_00;
    endcase
  endfunction

endpackage

// File: rtl/tmds_ctrl_detect.sv
// Registered DVI control-token matcher; ctrl holds its last decoded value between hits.
module tmds_ctrl_detect
  import tmds_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic [SYMBOL_W-1:0] i_symbol,
  output logic                o_ctrl_hit,
  output logic [1:0]          o_ctrl
);

  logic [2:0] w_dec;
  logic       r_ctrl_hit;
  logic [1:0] r_ctrl;

  assign w_dec = ctrl_decode(i_symbol);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_ctrl_hit <= 1'b0;
      r_ctrl     <= 2'b00;
    end else begin
      r_ctrl_hit <= w_dec[2];
      if (w_dec[2]) begin
        r_ctrl <= w_dec[1:0];
      end
    end
  end

  assign o_ctrl_hit = r_ctrl_hit;
  assign o_ctrl     = r_ctrl;

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS channel word aligner: bit-slips a 20-bit window until control tokens repeat during blanking,
// then holds the offset until tokens disappear for LOSS_TIMEOUT cycles.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_DWELL = 2048,
  parameter int unsigned LOCK_RUN     = 8,
  parameter int unsigned LOSS_TIMEOUT = 65535
) (
  input  logic                i_clk_recovery,
  input  logic                i_rst,
  input  logic                i_pll_locked,
  input  logic [SYMBOL_W-1:0] i_raw_word,
  output logic [SYMBOL_W-1:0] o_aligned_word,
  output logic                o_ctrl_hit,
  output logic [1:0]          o_ctrl,
  output logic [OFFSET_W-1:0] o_offset,
  output logic                o_locked,
  output logic                o_lock_lost
);

  localparam int unsigned DWELL_W = $clog2(SEARCH_DWELL) + 1;
  localparam int unsigned RUN_W   = $clog2(LOCK_RUN) + 1;
  localparam int unsigned LOSS_W  = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
  localparam logic [RUN_W-1:0]    RUN_DONE   = RUN_W'(LOCK_RUN);
  localparam logic [LOSS_W-1:0]   LOSS_DONE  = LOSS_W'(LOSS_TIMEOUT);
  localparam logic [OFFSET_W-1:0] OFFSET_MAX = OFFSET_W'(SYMBOL_W - 1);

  logic                  w_clr;
  logic [2*SYMBOL_W-1:0] w_window;
  logic                  w_hit;
  logic [RUN_W-1:0]      w_run_inc;
  logic [LOSS_W-1:0]     w_loss_inc;

  logic [SYMBOL_W-1:0] r_prev_word;
  logic [SYMBOL_W-1:0] r_aligned_word;
  align_state_e        r_state, w_state_d;
  logic [DWELL_W-1:0]  r_dwell_cnt, w_dwell_d;
  logic [RUN_W-1:0]    r_run_cnt, w_run_d;
  logic [LOSS_W-1:0]   r_loss_cnt, w_loss_d;
  logic [1:0]          r_holdoff, w_holdoff_d;
  logic [OFFSET_W-1:0] r_offset, w_offset_d;
  logic                r_locked, w_locked_d;
  logic                r_lock_lost, w_lock_lost_d;

  assign w_clr    = i_rst | ~i_pll_locked;
  assign w_window = {i_raw_word, r_prev_word};

  // History word is free-running so the window is valid on the first cycle out of reset.
  always_ff @(posedge i_clk_recovery) begin
    r_prev_word <= i_raw_word;
  end

  always_ff @(posedge i_clk_recovery) begin
    if (w_clr) begin
      r_aligned_word <= '0;
    end else begin
      r_aligned_word <= SYMBOL_W'(w_window >> r_offset);
    end
  end

  tmds_ctrl_detect u_ctrl_detect (
    .i_clk      (i_clk_recovery),
    .i_clr      (w_clr),
    .i_symbol   (r_aligned_word),
    .o_ctrl_hit (o_ctrl_hit),
    .o_ctrl     (o_ctrl)
  );

  // Hits are masked for two cycles after a slip: they still describe the old offset.
  assign w_hit      = o_ctrl_hit && (r_holdoff == 2'd0);
  assign w_run_inc  = r_run_cnt + 1'b1;
  assign w_loss_inc = r_loss_cnt + 1'b1;

  always_comb begin
    w_state_d     = r_state;
    w_dwell_d     = r_dwell_cnt;
    w_run_d       = r_run_cnt;
    w_loss_d      = r_loss_cnt;
    w_holdoff_d   = (r_holdoff != 2'd0) ? r_holdoff - 2'd1 : r_holdoff;
    w_offset_d    = r_offset;
    w_locked_d    = r_locked;
    w_lock_lost_d = 1'b0;
    unique case (r_state)
      SEARCH, VERIFY: begin
        if (r_dwell_cnt == DWELL_LAST) begin
          w_offset_d  = (r_offset == OFFSET_MAX) ? '0 : r_offset + 1'b1;
          w_dwell_d   = '0;
          w_run_d     = '0;
          w_holdoff_d = 2'd2;
          w_state_d   = SEARCH;
        end else begin
          w_dwell_d = r_dwell_cnt + 1'b1;
          if (r_state == SEARCH) begin
            if (w_hit) begin
              w_state_d = VERIFY;
              w_run_d   = RUN_W'(1);
            end
          end else if (w_hit) begin
            w_run_d = w_run_inc;
            if (w_run_inc == RUN_DONE) begin
              w_state_d  = LOCKED;
              w_locked_d = 1'b1;
              w_loss_d   = '0;
            end
          end else begin
            w_state_d = SEARCH;
            w_run_d   = '0;
          end
        end
      end
      LOCKED: begin
        if (w_hit) begin
          w_loss_d = '0;
        end else if (w_loss_inc == LOSS_DONE) begin
          w_state_d     = SEARCH;
          w_locked_d    = 1'b0;
          w_lock_lost_d = 1'b1;
          w_dwell_d     = '0;
          w_run_d       = '0;
          w_loss_d      = '0;
        end else begin
          w_loss_d = w_loss_inc;
        end
      end
      default: w_state_d = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk_recovery) begin
    if (w_clr) begin
      r_state     <= SEARCH;
      r_dwell_cnt <= '0;
      r_run_cnt   <= '0;
      r_loss_cnt  <= '0;
      r_holdoff   <= 2'd0;
      r_offset    <= '0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_dwell_cnt <= w_dwell_d;
      r_run_cnt   <= w_run_d;
      r_loss_cnt  <= w_loss_d;
      r_holdoff   <= w_holdoff_d;
      r_offset    <= w_offset_d;
      r_locked    <= w_locked_d;
      r_lock_lost <= w_lock_lost_d;
    end
  end

  assign o_aligned_word = r_aligned_word;
  assign o_offset       = r_offset;
  assign o_locked       = r_locked;
  assign o_lock_lost    = r_lock_lost;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: serialises symbol streams at a chosen bit phase.
module tb_tmds_word_aligner;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] NOISE = 10'b1110001101;
  localparam logic [9:0] RUNS  = 10'h01F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll = 1'b1;
  logic [9:0] raw = '0;
  logic [9:0] aligned_word;
  logic       ctrl_hit;
  logic [1:0] ctrl;
  logic [3:0] offset;
  logic       locked;
  logic       lock_lost;

  int         total = 0;
  int         bad = 0;
  int         phase = 0;
  int         lost_pulses = 0;
  int         seen_lock = 0;
  logic [9:0] prev_sym = '0;

  tmds_word_aligner #(
    .SEARCH_DWELL (16),
    .LOCK_RUN     (8),
    .LOSS_TIMEOUT (100)
  ) dut (
    .i_clk_recovery (clk),
    .i_rst          (rst),
    .i_pll_locked   (pll),
    .i_raw_word     (raw),
    .o_aligned_word (aligned_word),
    .o_ctrl_hit     (ctrl_hit),
    .o_ctrl         (ctrl),
    .o_offset       (offset),
    .o_locked       (locked),
    .o_lock_lost    (lock_lost)
  );

  always #5 clk = ~clk;

  // Raw word n carries stream bits [10n-p, 10n-p+9]; the aligner must pick offset p.
  function automatic logic [9:0] ser(input logic [9:0] cur, input logic [9:0] prv, input int p);
    logic [19:0] pair;
    pair = {cur, prv};
    return 10'(pair >> (10 - p));
  endfunction

  function automatic logic [9:0] rnd_sym();
    logic [9:0] s;
    s = 10'($urandom);
    if (s == T00 || s == T01 || s == T10 || s == T11) s = s ^ 10'h001;
    return s;
  endfunction

  task automatic feed(input logic [9:0] sym);
    raw = ser(sym, prev_sym, phase);
    prev_sym = sym;
    @(posedge clk);
    #1;
    if (lock_lost === 1'b1) lost_pulses++;
    if (locked === 1'b1) seen_lock++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_aligned"}, 32'(aligned_word), 32'd0);
    chk({tag, "_ctrl_hit"}, 32'(ctrl_hit), 32'd0);
    chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
    chk({tag, "_offset"}, 32'(offset), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
  endtask

  task automatic do_reset(input logic [9:0] sym);
    rst = 1'b1;
    pll = 1'b1;
    repeat (3) feed(sym);
    rst = 1'b0;
    lost_pulses = 0;
    seen_lock = 0;
  endtask

  initial begin
    // Phase 0, T11 from the first cycle: lock after 1+1+LOCK_RUN edges.
    phase = 0;
    prev_sym = T11;
    do_reset(T11);
    chk_cleared("reset");
    for (int n = 0; n < 10; n++) begin
      feed(T11);
      if (n == 8) chk("p0_locked_early", 32'(locked), 32'd0);
    end
    chk("p0_locked", 32'(locked), 32'd1);
    chk("p0_offset", 32'(offset), 32'd0);
    chk("p0_ctrl", 32'(ctrl), 32'd3);
    chk("p0_aligned", 32'(aligned_word), 32'(T11));

    // One cycle of PLL unlock: full clear, no lock_lost, then re-acquire.
    pll = 1'b0;
    feed(T11);
    pll = 1'b1;
    chk_cleared("pll_drop");
    for (int k = 1; k <= 10; k++) begin
      feed(T11);
      if (k == 9) chk("pll_relock_early", 32'(locked), 32'd0);
    end
    chk("pll_relock", 32'(locked), 32'd1);
    chk("pll_no_lost", 32'(lost_pulses), 32'd0);

    // Phase 3, T00: slips at every 16th edge, locks after the third slip.
    phase = 3;
    do_reset(T00);
    for (int n = 0; n < 60; n++) begin
      feed(T00);
      if (n == 14) chk("p3_off0", 32'(offset), 32'd0);
      if (n == 15) chk("p3_off1", 32'(offset), 32'd1);
      if (n == 31) chk("p3_off2", 32'(offset), 32'd2);
      if (n == 47) chk("p3_off3", 32'(offset), 32'd3);
      if (n == 56) chk("p3_locked_early", 32'(locked), 32'd0);
      if (n == 57) chk("p3_locked", 32'(locked), 32'd1);
    end
    chk("p3_offset", 32'(offset), 32'd3);
    chk("p3_aligned", 32'(aligned_word), 32'(T00));
    chk("p3_ctrl", 32'(ctrl), 32'd0);
    chk("p3_ctrl_hit", 32'(ctrl_hit), 32'd1);

    // Phase 7, T10 with the fifth token at offset 7 corrupted: VERIFY aborts in place.
    phase = 7;
    do_reset(T10);
    for (int n = 0; n < 127; n++) begin
      feed((n == 115) ? NOISE : T10);
      if (n == 111) chk("p7_off7", 32'(offset), 32'd7);
      if (n == 119) chk("p7_abort_offset", 32'(offset), 32'd7);
      if (n == 121) chk("p7_abort_unlocked", 32'(locked), 32'd0);
      if (n == 125) chk("p7_locked_early", 32'(locked), 32'd0);
    end
    chk("p7_locked", 32'(locked), 32'd1);
    chk("p7_offset", 32'(offset), 32'd7);
    chk("p7_ctrl", 32'(ctrl), 32'd2);

    // Loss of tokens: 99 misses then a token retains lock; 100 misses drop it.
    for (int k = 0; k < 206; k++) begin
      feed((k == 99) ? T10 : rnd_sym());
      if (k == 102) chk("loss_retained", 32'(locked), 32'd1);
      if (k == 201) chk("loss_pre_pulse", 32'(lock_lost), 32'd0);
      if (k == 201) chk("loss_pre_locked", 32'(locked), 32'd1);
      if (k == 202) chk("loss_pulse", 32'(lock_lost), 32'd1);
      if (k == 202) chk("loss_unlocked", 32'(locked), 32'd0);
      if (k == 203) chk("loss_pulse_end", 32'(lock_lost), 32'd0);
    end
    chk("loss_pulse_count", 32'(lost_pulses), 32'd1);
    chk("loss_offset", 32'(offset), 32'd7);

    // Phase 9, no tokens anywhere: offset walks to 9 and wraps to 0.
    phase = 9;
    do_reset(RUNS);
    for (int n = 0; n < 161; n++) begin
      feed(RUNS);
      if (n == 143) chk("p9_off9", 32'(offset), 32'd9);
      if (n == 158) chk("p9_off9_hold", 32'(offset), 32'd9);
      if (n == 159) chk("p9_wrap", 32'(offset), 32'd0);
    end
    chk("p9_never_locked", 32'(seen_lock), 32'd0);
    chk("p9_no_hit", 32'(ctrl_hit), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmds_word_aligner.md
Name: tmds_word_aligner

Overview:
- Receive-side word aligner for one TMDS channel. It is the stage downstream of the recovered-clock PLL and the 1:10 deserializer.
- Input is a raw 10-bit word per recovered pixel clock, at an arbitrary bit phase. The block bit-slips a 20-bit window until DVI control tokens appear consistently during blanking.
- Output is an aligned 10-bit TMDS symbol stream plus lock status, for the downstream TMDS decoder and the passthrough re-encoder.
- One instance is used per data channel (gpdi_in[2:0]).

Parameters:
- SEARCH_DWELL, 2048: cycles spent at each offset before slipping. Must exceed one video line; 720p is 1650 clocks.
- LOCK_RUN, 8: consecutive control-token cycles required to declare lock.
- LOSS_TIMEOUT, 65535: cycles without any control token, while locked, before dropping lock.

Ports:
- clk_recovery  in  1  recovered pixel clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock. While low, the block behaves exactly as in reset.
- raw_word  in  10  deserialized word; bit 0 is the earliest bit received. Valid every cycle.
- aligned_word  out  10  aligned TMDS symbol.
- ctrl_hit  out  1  aligned_word is one of the four control tokens.
- ctrl  out  2  decoded {C1,C0} when ctrl_hit=1; holds its last value otherwise.
- offset  out  4  current slip offset, 0..9.
- locked  out  1  alignment locked.
- lock_lost  out  1  one-cycle pulse when leaving LOCKED.

Behaviour:
- Reset values:
  - Outputs aligned_word=0, ctrl_hit=0, ctrl=0, offset=0, locked=0, lock_lost=0.
  - State SEARCH; all counters 0; holdoff=0.
- Reset/pll_locked priority: rst or !pll_locked has priority over all other logic in every state. Taking effect mid-lock clears everything, and lock_lost is NOT pulsed.
- Window:
  - prev_word <= raw_word every cycle.
  - window = {raw_word, prev_word} (20 bits, prev in low bits).
  - aligned_word <= window[offset +: 10], so latency is 1 cycle from raw_word.
- Control tokens (bit 9..0):
  - 1101010100 -> ctrl 00
  - 0010101011 -> ctrl 01
  - 0101010100 -> ctrl 10
  - 1010101011 -> ctrl 11
- Detection registration: ctrl_hit and ctrl are registered from aligned_word, 1 cycle after aligned_word. The FSM consumes the registered ctrl_hit.
- dwell_cnt:
  - Increments every cycle in SEARCH and VERIFY; it is not cleared on entering VERIFY.
  - At SEARCH_DWELL-1 in SEARCH or VERIFY: offset <= (offset==9) ? 0 : offset+1; dwell_cnt <= 0; state <= SEARCH; holdoff <= 2.
  - While holdoff != 0, it decrements and ctrl_hit is ignored by the FSM (stale pipeline words).
- SEARCH: a valid ctrl_hit moves to VERIFY with run_cnt=1.
- VERIFY:
  - ctrl_hit: run_cnt+1.
  - On the hit that makes run_cnt==LOCK_RUN: go to LOCKED, locked=1 next cycle, loss_cnt=0.
  - Any non-hit returns to SEARCH with run_cnt=0 and offset unchanged.
  - A dwell expiry in the same cycle as a hit wins: slip and go to SEARCH.
- LOCKED:
  - ctrl_hit clears loss_cnt; otherwise loss_cnt increments. Offset is frozen.
  - When loss_cnt reaches LOSS_TIMEOUT: go to SEARCH, locked=0, lock_lost=1 for one cycle, dwell_cnt=0, offset unchanged.
- Counter widths: $clog2 of their parameter + 1. No counter wraps; each saturates via the transition that consumes it.

Decomposition:
- Package tmds_pkg holds:
  - the four control-token constants and the token-to-ctrl mapping;
  - the FSM state enum (SEARCH, VERIFY, LOCKED);
  - SYMBOL_W=10 and OFFSET_W=4.
- Sub-module tmds_ctrl_detect: a registered token matcher, 10-bit in -> ctrl_hit, ctrl. It is reused later by the TMDS decoder.

Test Plan:
- Repeating token 1101010100 with bitstream phase 3, SEARCH_DWELL=16 -> offset steps 0,1,2,3; locked=1 within 60 cycles; offset=3; aligned_word=1101010100; ctrl=00.
- Phase 0, token 1010101011 from the first cycle -> locked rises exactly 1+1+LOCK_RUN cycles after reset release; offset=0; ctrl=11.
- Phase 7 with the control run broken at the 5th token by pseudo-random data, then clean -> VERIFY aborts to SEARCH at the same offset without slipping; lock is acquired later at offset 7.
- Locked, then random non-token data for LOSS_TIMEOUT=100 cycles -> lock_lost pulses exactly once at cycle 100; locked=0; offset unchanged. Tokens on cycle 99 instead -> lock is retained.
- Phase 9 with no tokens ever -> offset wraps 9->0 after ten dwells; locked stays 0.
- Locked, then pll_locked deasserted for 1 cycle -> next cycle all outputs are at reset values with no lock_lost pulse, followed by re-acquisition.
